// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// instruction width and the system-bus read tag.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int INST_WIDTH = 32;

    // System-bus command and target encodings used to build request tags.
    localparam int SYSBUS_READ   = 1;
    localparam int SYSBUS_MEMORY = 1;

    localparam int READ_MEMORY_TAG = (SYSBUS_READ << 8) | (SYSBUS_MEMORY << 12);

endpackage

// File: rtl/inst_fifo.sv
// Synchronous instruction buffer: up to PUSH_PORTS writes and one read per
// cycle, flush input and a free-entry count for the fetch throttle.
module inst_fifo #(
    parameter int WIDTH      = 96,
    parameter int DEPTH      = 32,
    parameter int PUSH_PORTS = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [PUSH_PORTS-1:0]               push_valid,
    input  logic [PUSH_PORTS-1:0][WIDTH-1:0]    push_data,
    input  logic                                pop,
    output logic [WIDTH-1:0]                    head,
    output logic                                empty,
    output logic [$clog2(DEPTH):0]              free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0]                mem [DEPTH];
    logic [AW:0]                     wr_ptr;
    logic [AW:0]                     rd_ptr;
    logic [AW:0]                     used;
    logic [AW:0]                     push_n;
    logic [PUSH_PORTS-1:0][AW-1:0]   slot;

    // Valid push lanes are packed into consecutive slots in lane order, so a
    // partially valid beat still lands lowest address first.
    always_comb begin
        push_n = '0;
        for (int j = 0; j < PUSH_PORTS; j++) begin
            slot[j] = wr_ptr[AW-1:0] + push_n[AW-1:0];
            if (push_valid[j]) begin
                push_n = push_n + PTR_ONE;
            end
        end
    end

    assign used  = wr_ptr - rd_ptr;
    assign empty = (used == '0);
    assign free  = DEPTH_W - used;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        for (int j = 0; j < PUSH_PORTS; j++) begin
            if (push_valid[j] && !flush) begin
                mem[slot[j]] <= push_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_n;
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues line-sized bus bursts, unpacks beats into
// 32-bit instructions and streams them with their PCs through a buffer.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 entry,
    input  logic                        redirect_valid,
    input  logic [63:0]                 redirect_pc,
    output logic                        bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    output logic                        bus_respack,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [31:0]                 inst,
    output logic [63:0]                 inst_pc,
    output logic                        halted
);

    localparam int BEATS      = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int IPB        = BUS_DATA_WIDTH / 32;
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FW         = $clog2(FIFO_DEPTH) + 1;
    localparam int EW         = INST_WIDTH + 64;

    localparam logic [63:0]              LINE_MASK  = 64'(LINE_BYTES - 1);
    localparam logic [63:0]              LINE_STEP  = 64'(LINE_BYTES);
    localparam logic [BW-1:0]            LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [BW-1:0]            BEAT_ONE   = BW'(1);
    localparam logic [FW-1:0]            LINE_SLOTS = FW'(LINE_WORDS);
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG    = BUS_TAG_WIDTH'(READ_MEMORY_TAG);

    fetch_state_t               state;
    logic [63:0]                fetch_pc;
    logic [63:0]                line_base;
    logic [BW-1:0]              beat_cnt;
    logic                       halt_pending;
    logic                       drain_after_ack;

    logic                       beat;
    logic                       last_beat;
    logic [IPB-1:0]             push_valid;
    logic [IPB-1:0][EW-1:0]     push_data;
    logic                       push_zero;

    logic [EW-1:0]              fifo_head;
    logic                       fifo_empty;
    logic [FW-1:0]              fifo_free;

    logic                       unused_bits;

    assign unused_bits = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

    assign beat      = bus_respcyc && ((state == RESP) || (state == DRAIN));
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Words below fetch_pc belong to the part of the line before the branch
    // target; comparing line offsets keeps this correct across a 2^64 wrap.
    always_comb begin
        logic [63:0] word_off;
        logic [31:0] word;
        push_valid = '0;
        push_data  = '0;
        push_zero  = 1'b0;
        for (int j = 0; j < IPB; j++) begin
            word         = bus_resp[32*j +: 32];
            word_off     = 64'(beat_cnt) * 64'(BEAT_BYTES) + 64'(4 * j);
            push_data[j] = {word, line_base + word_off};
            if ((state == RESP) && bus_respcyc && !redirect_valid &&
                (word_off >= (fetch_pc & LINE_MASK))) begin
                push_valid[j] = 1'b1;
                if (word == '0) begin
                    push_zero = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            fetch_pc        <= {entry[63:2], 2'b00};
            line_base       <= '0;
            beat_cnt        <= '0;
            halt_pending    <= 1'b0;
            drain_after_ack <= 1'b0;
            halted          <= 1'b0;
            bus_reqcyc      <= 1'b0;
            bus_req         <= '0;
            bus_reqtag      <= '0;
            bus_respack     <= 1'b0;
        end else begin
            if (beat) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_ONE;
            end

            case (state)
                IDLE: begin
                    if (!redirect_valid && !halted && (fifo_free >= LINE_SLOTS)) begin
                        state      <= REQ;
                        bus_reqcyc <= 1'b1;
                        bus_req    <= BUS_DATA_WIDTH'(fetch_pc & ~LINE_MASK);
                        bus_reqtag <= REQ_TAG;
                        line_base  <= fetch_pc & ~LINE_MASK;
                    end
                end
                REQ: begin
                    if (bus_reqack) begin
                        bus_reqcyc      <= 1'b0;
                        bus_respack     <= 1'b1;
                        drain_after_ack <= 1'b0;
                        state           <= (redirect_valid || drain_after_ack) ? DRAIN : RESP;
                    end else if (redirect_valid) begin
                        drain_after_ack <= 1'b1;
                    end
                end
                RESP: begin
                    if (beat && last_beat) begin
                        state        <= IDLE;
                        bus_respack  <= 1'b0;
                        fetch_pc     <= line_base + LINE_STEP;
                        halted       <= halt_pending | push_zero;
                        halt_pending <= 1'b0;
                    end else begin
                        if (beat) begin
                            halt_pending <= halt_pending | push_zero;
                        end
                        if (redirect_valid) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat && last_beat) begin
                        state       <= IDLE;
                        bus_respack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A redirect overrides any fetch_pc / halt update made above.
            if (redirect_valid) begin
                fetch_pc     <= {redirect_pc[63:2], 2'b00};
                halted       <= 1'b0;
                halt_pending <= 1'b0;
            end
        end
    end

    inst_fifo #(
        .WIDTH      (EW),
        .DEPTH      (FIFO_DEPTH),
        .PUSH_PORTS (IPB)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push_valid (push_valid),
        .push_data  (push_data),
        .pop        (inst_ready),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .free       (fifo_free)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head[EW-1 -: INST_WIDTH];
    assign inst_pc    = fifo_head[63:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: bus responder backed by an
// address-valued memory, instruction collector and per-scenario checks.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        halted;

    logic [63:0] req_q[$];
    logic [12:0] tag_q[$];
    logic [31:0] got_inst_q[$];
    logic [63:0] got_pc_q[$];

    int          rsp_state;
    int          cur_beat;
    int          unacked_beats;
    int          unstable_reqs;
    logic [63:0] rsp_base;
    logic        zero_en;
    logic [63:0] zero_addr;

    int          n_checks;
    int          n_fail;

    inst_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (zero_en && (a == zero_addr)) ? 32'h0 : a[31:0];
    endfunction

    task automatic drive_beat();
        logic [63:0] a;
        a           = rsp_base + 64'(cur_beat) * 64'd8;
        bus_resp    = {mem_word(a + 64'd4), mem_word(a)};
        bus_resptag = 13'($urandom_range(0, 8191));
        bus_respcyc = 1'b1;
        if (bus_respack !== 1'b1) unacked_beats++;
    endtask

    // Bus responder: one cycle of request hold before ack, then 8 back-to-back beats.
    initial begin
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        rsp_state   = 0;
        cur_beat    = 0;
        rsp_base    = '0;
        forever begin
            @(negedge clk);
            bus_reqack  = 1'b0;
            bus_respcyc = 1'b0;
            if (reset) begin
                rsp_state = 0;
            end else begin
                case (rsp_state)
                    0: if (bus_reqcyc === 1'b1) begin
                        req_q.push_back(bus_req);
                        tag_q.push_back(bus_reqtag);
                        rsp_base  = bus_req;
                        rsp_state = 3;
                    end
                    3: begin
                        if (bus_reqcyc !== 1'b1 || bus_req !== rsp_base) unstable_reqs++;
                        bus_reqack = 1'b1;
                        rsp_state  = 1;
                    end
                    1: begin
                        cur_beat  = 0;
                        drive_beat();
                        rsp_state = 2;
                    end
                    default: begin
                        if (cur_beat == 7) begin
                            rsp_state = 0;
                        end else begin
                            cur_beat++;
                            drive_beat();
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && inst_valid === 1'b1 && inst_ready === 1'b1) begin
                got_inst_q.push_back(inst);
                got_pc_q.push_back(inst_pc);
            end
        end
    end

    task automatic do_reset(input logic [63:0] e);
        @(negedge clk);
        #1;
        reset          = 1'b1;
        entry          = e;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        zero_en        = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        req_q.delete();
        tag_q.delete();
        got_inst_q.delete();
        got_pc_q.delete();
        unacked_beats = 0;
        unstable_reqs = 0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL reset_reqcyc got %b want 0", bus_reqcyc); end
        n_checks++; if (bus_respack !== 1'b0) begin n_fail++; $display("FAIL reset_respack got %b want 0", bus_respack); end
        n_checks++; if (bus_req !== 64'h0) begin n_fail++; $display("FAIL reset_req got %h want 0", bus_req); end
        n_checks++; if (bus_reqtag !== 13'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", bus_reqtag); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    endtask

    task automatic test_basic();
        do_reset(64'h1000);
        inst_ready = 1'b1;
        for (int i = 0; i < 50 && !(rsp_state == 2 && cur_beat == 0); i++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid got %b want 1", inst_valid); end
        n_checks++; if (inst_pc !== 64'h1000) begin n_fail++; $display("FAIL basic_latency_pc got %h want 1000", inst_pc); end
        for (int i = 0; i < 200 && (req_q.size() < 2 || got_pc_q.size() < 16); i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (req_q.size() < 2 || got_pc_q.size() < 16) begin
            n_fail++;
            $display("FAIL basic_timeout got reqs=%0d words=%0d want reqs=2 words=16", req_q.size(), got_pc_q.size());
        end else begin
            n_checks++; if (req_q[0] !== 64'h1000) begin n_fail++; $display("FAIL basic_req0 got %h want 1000", req_q[0]); end
            n_checks++; if (tag_q[0] !== 13'h1100) begin n_fail++; $display("FAIL basic_tag got %h want 1100", tag_q[0]); end
            n_checks++; if (req_q[1] !== 64'h1040) begin n_fail++; $display("FAIL basic_req1 got %h want 1040", req_q[1]); end
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (got_pc_q[i] !== 64'h1000 + 64'(4 * i) || got_inst_q[i] !== 32'h1000 + 32'(4 * i)) begin
                    n_fail++;
                    $display("FAIL basic_word%0d got pc=%h inst=%h want %h", i, got_pc_q[i], got_inst_q[i], 64'h1000 + 64'(4 * i));
                end
            end
        end
        n_checks++; if (unacked_beats != 0) begin n_fail++; $display("FAIL basic_respack got %0d unacked beats want 0", unacked_beats); end
        n_checks++; if (unstable_reqs != 0) begin n_fail++; $display("FAIL basic_req_stable got %0d unstable want 0", unstable_reqs); end
    endtask

    task automatic test_offset();
        do_reset(64'h1008);
        inst_ready = 1'b1;
        for (int i = 0; i < 200 && got_pc_q.size() < 15; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (got_pc_q.size() < 15 || req_q.size() < 1) begin
            n_fail++;
            $display("FAIL offset_timeout got words=%0d want 15", got_pc_q.size());
        end else begin
            n_checks++; if (req_q[0] !== 64'h1000) begin n_fail++; $display("FAIL offset_req got %h want 1000", req_q[0]); end
            for (int i = 0; i < 14; i++) begin
                n_checks++;
                if (got_pc_q[i] !== 64'h1008 + 64'(4 * i)) begin
                    n_fail++;
                    $display("FAIL offset_word%0d got %h want %h", i, got_pc_q[i], 64'h1008 + 64'(4 * i));
                end
            end
            n_checks++; if (got_pc_q[14] !== 64'h1040) begin n_fail++; $display("FAIL offset_next_line got %h want 1040", got_pc_q[14]); end
        end
    endtask

    task automatic test_throttle();
        do_reset(64'h1000);
        repeat (80) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (req_q.size() != 2) begin n_fail++; $display("FAIL throttle_two_reqs got %0d want 2", req_q.size()); end
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL throttle_idle got %b want 0", bus_reqcyc); end
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h1000) begin n_fail++; $display("FAIL throttle_head got v=%b pc=%h want 1/1000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        repeat (15) begin
            @(negedge clk);
            #1;
        end
        inst_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (got_pc_q.size() != 15) begin n_fail++; $display("FAIL throttle_pops got %0d want 15", got_pc_q.size()); end
        n_checks++; if (req_q.size() != 2) begin n_fail++; $display("FAIL throttle_15_pops got %0d reqs want 2", req_q.size()); end
        inst_ready = 1'b1;
        @(negedge clk);
        #1;
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && req_q.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (req_q.size() < 3) begin
            n_fail++;
            $display("FAIL throttle_resume got %0d reqs want 3", req_q.size());
        end else if (req_q[2] !== 64'h1080) begin
            n_fail++;
            $display("FAIL throttle_resume got %h want 1080", req_q[2]);
        end
    endtask

    task automatic test_redirect();
        do_reset(64'h1000);
        for (int i = 0; i < 50 && !(rsp_state == 2 && cur_beat == 3); i++) begin
            @(negedge clk);
            #1;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2004;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush got %b want 0", inst_valid); end
        for (int i = 0; i < 50 && req_q.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (req_q.size() < 2) begin
            n_fail++;
            $display("FAIL redirect_req got %0d reqs want 2", req_q.size());
        end else if (req_q[1] !== 64'h2000) begin
            n_fail++;
            $display("FAIL redirect_req got %h want 2000", req_q[1]);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 50 && got_pc_q.size() < 1; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (got_pc_q.size() < 1) begin
            n_fail++;
            $display("FAIL redirect_first got no word want pc 2004");
        end else if (got_pc_q[0] !== 64'h2004 || got_inst_q[0] !== 32'h2004) begin
            n_fail++;
            $display("FAIL redirect_first got pc=%h inst=%h want 2004", got_pc_q[0], got_inst_q[0]);
        end
        n_checks++; if (unacked_beats != 0) begin n_fail++; $display("FAIL redirect_drain_ack got %0d unacked want 0", unacked_beats); end
    endtask

    task automatic test_halt();
        do_reset(64'h1000);
        zero_en    = 1'b1;
        zero_addr  = 64'h1010;
        inst_ready = 1'b1;
        for (int i = 0; i < 60 && halted !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set got %b want 1", halted); end
        repeat (40) begin
            @(negedge clk);
            #1;
        end
        n_checks++; if (req_q.size() != 1) begin n_fail++; $display("FAIL halt_no_req got %0d reqs want 1", req_q.size()); end
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL halt_reqcyc got %b want 0", bus_reqcyc); end
        n_checks++;
        if (got_pc_q.size() != 16) begin
            n_fail++;
            $display("FAIL halt_drain got %0d words want 16", got_pc_q.size());
        end else begin
            n_checks++; if (got_inst_q[4] !== 32'h0) begin n_fail++; $display("FAIL halt_zero_word got %h want 0", got_inst_q[4]); end
            n_checks++; if (got_inst_q[5] !== 32'h1014) begin n_fail++; $display("FAIL halt_after_zero got %h want 1014", got_inst_q[5]); end
        end
        zero_en        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        @(negedge clk);
        #1;
        redirect_valid = 1'b0;
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %b want 0", halted); end
        for (int i = 0; i < 30 && req_q.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (req_q.size() < 2) begin
            n_fail++;
            $display("FAIL halt_restart got %0d reqs want 2", req_q.size());
        end else if (req_q[1] !== 64'h3000) begin
            n_fail++;
            $display("FAIL halt_restart got %h want 3000", req_q[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset(64'h1000);
        for (int i = 0; i < 50 && !(rsp_state == 2 && cur_beat == 3); i++) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        entry = 64'h5000;
        @(negedge clk);
        #1;
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL midrst_reqcyc got %b want 0", bus_reqcyc); end
        n_checks++; if (bus_respack !== 1'b0) begin n_fail++; $display("FAIL midrst_respack got %b want 0", bus_respack); end
        n_checks++; if (bus_req !== 64'h0) begin n_fail++; $display("FAIL midrst_req got %h want 0", bus_req); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_inst_valid got %b want 0", inst_valid); end
        reset = 1'b0;
        for (int i = 0; i < 30 && req_q.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (req_q.size() < 2) begin
            n_fail++;
            $display("FAIL midrst_restart got %0d reqs want 2", req_q.size());
        end else if (req_q[1] !== 64'h5000) begin
            n_fail++;
            $display("FAIL midrst_restart got %h want 5000", req_q[1]);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        unacked_beats  = 0;
        unstable_reqs  = 0;
        reset          = 1'b1;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;
        zero_en        = 1'b0;
        zero_addr      = 64'h0;

        test_reset();
        test_basic();
        test_offset();
        test_throttle();
        test_redirect();
        test_halt();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
